// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-queue constants: FSM state encodings used by ifetch_queue.
package ifetch_queue_pkg;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'b00,
    IFQ_WAIT = 2'b01,
    IFQ_DROP = 2'b10
  } ifq_state_e;

endpackage

// File: rtl/ifetch_queue_if.sv
// PC-side, instruction-memory and decode-side signals of the fetch queue.
// The queue itself uses the slave view; its environment uses the master view.
interface ifetch_queue_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] pc_in;
  logic          pc_valid;
  logic          pc_ready;
  logic          redirect;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          ins_valid;
  logic [DW-1:0] ins_data;
  logic [AW-1:0] ins_pc;
  logic          ins_ready;

  modport slave (
    input  pc_in, pc_valid, redirect, mem_ack, mem_rdata, ins_ready,
    output pc_ready, mem_req, mem_addr, ins_valid, ins_data, ins_pc
  );

  modport master (
    output pc_in, pc_valid, redirect, mem_ack, mem_rdata, ins_ready,
    input  pc_ready, mem_req, mem_addr, ins_valid, ins_data, ins_pc
  );
endinterface

// File: rtl/ifq_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; head is registered storage, push-to-visible 1 cycle.
// Caller must not push when full or pop when empty; flush overrides push/pop.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic          vld_o,
  output logic [W-1:0]  head_dat_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count_o    = cnt_q;
  assign vld_o      = (cnt_q != '0);
  assign head_dat_o = mem_q[rd_q];
endmodule

// File: rtl/ifetch_queue.sv
// Fetch queue: accepted PC -> mem_req next cycle, one outstanding read; ack -> ins_valid after 1 cycle
// (0 cycles with IFQ_BYPASS_EN). pc_ready drops when FIFO + in-flight fill DEPTH, or on redirect/DROP.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          Reset,
  ifetch_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  ifq_state_e     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [CW-1:0]  count;
  logic           fifo_vld;
  logic [AW+DW-1:0] head;
  logic           room, pc_ready_c, accept, ack_ok, push, pop;

  always_comb begin
    room       = (int'(count) + int'(state_q == IFQ_WAIT)) < DEPTH;
    pc_ready_c = Reset && !bus.redirect && room &&
                 (state_q == IFQ_IDLE || (state_q == IFQ_WAIT && bus.mem_ack));
    accept     = bus.pc_valid && pc_ready_c;
    ack_ok     = (state_q == IFQ_WAIT) && bus.mem_ack && !bus.redirect;
  end

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp           = ack_ok && (count == '0);
  assign bus.ins_valid = fifo_vld || byp;
  assign bus.ins_data  = byp ? bus.mem_rdata : head[DW-1:0];
  assign bus.ins_pc    = byp ? addr_q : head[AW+DW-1:DW];
  // A bypassed word that decode takes immediately never enters the FIFO.
  assign push          = ack_ok && !(byp && bus.ins_ready);
`else
  assign bus.ins_valid = fifo_vld;
  assign bus.ins_data  = head[DW-1:0];
  assign bus.ins_pc    = head[AW+DW-1:DW];
  assign push          = ack_ok;
`endif

  assign pop          = fifo_vld && bus.ins_ready;
  assign bus.pc_ready = pc_ready_c;
  assign bus.mem_req  = (state_q != IFQ_IDLE);
  assign bus.mem_addr = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IFQ_IDLE: if (accept) begin
        state_d = IFQ_WAIT;
        addr_d  = bus.pc_in;
      end
      IFQ_WAIT: begin
        if (bus.redirect) begin
          state_d = bus.mem_ack ? IFQ_IDLE : IFQ_DROP;
        end else if (bus.mem_ack) begin
          state_d = accept ? IFQ_WAIT : IFQ_IDLE;
          if (accept) addr_d = bus.pc_in;
        end
      end
      IFQ_DROP: if (bus.mem_ack) state_d = IFQ_IDLE;
      default:  state_d = IFQ_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IFQ_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH), .W(AW + DW), .CW(CW)) u_fifo (
    .CLK        (CLK),
    .Reset      (Reset),
    .push_i     (push),
    .push_dat_i ({addr_q, bus.mem_rdata}),
    .pop_i      (pop),
    .flush_i    (bus.redirect),
    .count_o    (count),
    .vld_o      (fifo_vld),
    .head_dat_o (head)
  );
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Consumer of the fetch-address stream from the program counter. Turns each accepted PC into an instruction-memory read (req/ack handshake) and buffers the returned {pc, instruction} pairs for the decode stage.
- Sits between the PC/next-PC logic and decode.
- Applies backpressure to the PC via pc_ready.
- Flushes wrong-path fetches on redirect (taken branch or jump).

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- AW, 32, address width.
- DW, 32, instruction width.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- pc_in  in  AW  fetch address offered by the PC.
- pc_valid  in  1  pc_in is valid this cycle.
- pc_ready  out  1  queue accepts pc_in this cycle.
- redirect  in  1  flush all queued and in-flight fetches.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  AW  read address; stable while mem_req=1.
- mem_ack  in  1  mem_rdata valid; completes the request.
- mem_rdata  in  DW  instruction word from memory.
- ins_valid  out  1  FIFO head valid.
- ins_data  out  DW  head instruction.
- ins_pc  out  AW  head instruction's PC.
- ins_ready  in  1  decode consumes head.

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE, count=0, FIFO pointers=0.
  - mem_req=0, mem_addr=0, ins_valid=0, ins_data=0, ins_pc=0; pc_ready=0 while Reset=0.
  - Reset mid-request abandons it; an ack arriving after release in IDLE is ignored.
- Outstanding requests: at most one.
- room = (count + (state==WAIT)) < DEPTH. Same-cycle pop is not credited.
- pc_ready = !redirect && room && (state==IDLE || (state==WAIT && mem_ack)).
- Accept = pc_valid && pc_ready. On accept: mem_addr<=pc_in, mem_req<=1, next state WAIT. This is 1-cycle latency from accept to mem_req.
- States:
  - IDLE:
    - mem_req=0.
    - Accept -> WAIT.
  - WAIT:
    - mem_req=1, mem_addr held.
    - mem_ack && !redirect: push {mem_addr, mem_rdata}. Then WAIT if a same-cycle accept occurred (back-to-back, new mem_addr), else IDLE.
    - redirect && !mem_ack -> DROP.
    - redirect && mem_ack: discard data -> IDLE.
  - DROP:
    - mem_req=1, mem_addr held.
    - On mem_ack, discard the data -> IDLE.
    - pc_ready=0.
    - redirect while in DROP: no change.
- Protocol: mem_req never deasserts before mem_ack.
- FIFO:
  - ins_valid = count!=0; ins_data/ins_pc = head entry.
  - Pop on ins_valid && ins_ready.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- redirect (synchronous, 1 cycle):
  - count<=0, pointers<=0, ins_valid=0 from next cycle.
  - Any push or pop in that cycle is discarded.
  - pc_valid in that cycle is ignored.
  - The first post-redirect PC is accepted no earlier than the next cycle (IDLE), or after the DROP ack.
- Alignment: pc_in is forwarded to mem_addr unmodified; alignment is the PC's responsibility.
- Halt behaviour: a repeated identical pc_in (PC halted) is fetched repeatedly; no deduplication.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count==0 and state==WAIT and mem_ack && !redirect, the word goes out combinationally: ins_valid=1, ins_data=mem_rdata, ins_pc=mem_addr.
  - If ins_ready=1 in that cycle it is consumed and not pushed; otherwise it is pushed as normal.
  - Latency from ack to decode: 0 cycles.
- Undefined:
  - ins_valid is purely registered FIFO state.
  - Ack-to-ins_valid latency: 1 cycle.

Decomposition:
- Shared constants header (with the existing PC-source defines) holds:
  - state encodings `IFQ_IDLE`=2'b00, `IFQ_WAIT`=2'b01, `IFQ_DROP`=2'b10.
- One sub-module, ifq_fifo:
  - synchronous FIFO, DEPTH×(AW+DW), with push/pop/flush, count, head outputs.
- FSM, handshake and bypass logic stay in ifetch_queue.

Test Plan:
- Reset then pc_valid=1 with pc_in=0x00400000; memory acks 2 cycles later with 0x8C010004 -> mem_req rises 1 cycle after accept, then ins_valid=1 with ins_pc=0x00400000, ins_data=0x8C010004 (1 cycle after ack; same cycle with IFQ_BYPASS_EN).
- Sequential PCs 0x0,0x4,0x8,... with ins_ready=0 and 1-cycle-ack memory -> exactly 4 entries (DEPTH=4); pc_ready=0 while full. Then ins_ready=1 -> drains in order; pc_ready returns.
- Zero-wait memory (mem_ack same cycle as mem_req), pc_valid always 1, ins_ready=1 -> back-to-back requests, one new mem_addr per cycle while in WAIT; no lost or duplicated PCs.
- redirect while WAIT on 0x10, ack 3 cycles later, with 2 entries queued -> FIFO empties next cycle; state DROP; mem_req held; the 0x10 data is never presented; then new PC 0x40 is fetched and delivered.
- redirect in the same cycle as mem_ack and ins_ready -> nothing pushed or popped; count=0; IDLE next cycle.
- Reset asserted mid-WAIT, then late ack after release -> all outputs 0; late ack ignored; no entry appears.
